dispensador_bebidas: RTL and testbench
======================================

DISPENSADOR_BEBIDAS -- requirements
Module: dispensador_bebidas

Interface
REQ-001 Parameter T_DOSIS, default 8; powder dosing-phase length in cycles, legal range 1..255.
REQ-002 Parameter T_AGUA, default 16; water-valve phase length in cycles, legal range 1..255.
REQ-003 Parameter T_MONEDA, default 4; coin-return phase length in cycles, legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cmd  input  3  command from the coffee-machine controller; it is a one-cycle code, 000 means idle.
REQ-007 dosis_cafe  output  1  coffee doser on.
REQ-008 dosis_te  output  1  tea doser on.
REQ-009 valvula_agua  output  1  hot-water valve open.
REQ-010 devuelve_moneda  output  1  coin-return solenoid on.
REQ-011 ocupado  output  1  a job is executing or pending.
REQ-012 cmd_perdido  output  1  one-cycle pulse; a command was dropped.

Function
REQ-013 Valid codes and their jobs:
- 100: MONEDA.
- 111: DOSIS_CAFE then AGUA.
- 110: DOSIS_TE then AGUA.
- 101: MONEDA then DOSIS_TE then AGUA.
REQ-014 Codes 000, 001, 010 and 011 are ignored and leave no state.
REQ-015 FSM states are IDLE, MONEDA, DOSIS_CAFE, DOSIS_TE and AGUA; each job remembers its remaining phase sequence.
REQ-016 Outputs are a Moore decode of the state:
- MONEDA drives devuelve_moneda.
- DOSIS_CAFE drives dosis_cafe.
- DOSIS_TE drives dosis_te.
- AGUA drives valvula_agua.
- All other outputs are 0 in each state, and all are 0 in IDLE.
REQ-017 A valid cmd sampled at edge k in IDLE with no pending job enters the job's first phase at edge k; the output is high from cycle k+1.
REQ-018 Each phase lasts exactly its parameter's number of cycles, timed by an 8-bit down-counter loaded at phase entry.
REQ-019 Consecutive phases of one job follow with no gap cycle.
REQ-020 At most one output is high in any cycle.
REQ-021 A one-entry pending register (valid bit plus 3-bit code) captures a valid cmd that arrives while not IDLE.
REQ-022 At the final cycle of a job, the next job is chosen in this order:
- the pending job, if one is held;
- otherwise a valid cmd arriving in that same cycle;
- otherwise IDLE.
The chosen job starts with no idle gap.
REQ-023 If the pending job is consumed and a valid cmd arrives in the same cycle, that cmd is written into pending; nothing is lost.
REQ-024 A valid cmd arriving while pending is full and not being consumed is dropped, and cmd_perdido pulses in the next cycle.
REQ-025 ocupado = (state != IDLE) OR pending valid.
REQ-026 Timers decrement only within the active phase and never wrap below 1; a phase exits when the count equals 1.

Reset
REQ-027 rst low asynchronously forces the following, mid-job included:
- state = IDLE;
- timer = 0;
- pending valid = 0;
- every output = 0.
REQ-028 After rst is released, the first command is accepted at the first rising edge where rst is high.

Structure
REQ-029 A shared package holds:
- the command code constants (CMD_NINGUNO, CMD_DEVUELVE, CMD_TE_DEVUELVE5, CMD_TE, CMD_CAFE);
- the state encoding;
- the default T_* values.
REQ-030 The phase timer is the sub-module temporizador_fase: a loadable 8-bit down-counter with load, enable and a terminal output (count == 1).

Verification
REQ-031 Default parameters, cmd=111 for one cycle: dosis_cafe high for 8 cycles, then valvula_agua for 16 cycles, then IDLE; ocupado high for 24 cycles.
REQ-032 cmd=101: devuelve_moneda for 4 cycles, dosis_te for 8, valvula_agua for 16, all contiguous.
REQ-033 cmd=110 then cmd=100 five cycles later: after the last valvula_agua cycle, devuelve_moneda rises the next cycle with no IDLE gap.
REQ-034 cmd=111, then 100, then 110 while busy: the 110 is dropped, cmd_perdido pulses once, and the 100 executes after the coffee job.
REQ-035 rst asserted during the AGUA phase: all outputs and ocupado fall immediately without waiting for a clock; after release, cmd=100 gives a 4-cycle coin return.
REQ-036 Codes 001, 010 and 011 applied in IDLE: no output activity and ocupado stays 0.

Source files
------------

// File: rtl/dispensador_bebidas_pkg.sv
// ---------------------------------------------------------------------------
// dispensador_bebidas_pkg
// Shared definitions for the drink dispenser:
//   - command codes sent by the coffee-machine controller
//   - phase/state encoding of the dispenser FSM
//   - default phase lengths (in clock cycles)
//   - helpers that map a command to its first phase and a phase to the next
//     phase of the same job
// ---------------------------------------------------------------------------
package dispensador_bebidas_pkg;

    // Command codes. Any code with bit 2 clear is "no command".
    localparam logic [2:0] CMD_NINGUNO      = 3'b000;
    localparam logic [2:0] CMD_DEVUELVE     = 3'b100;
    localparam logic [2:0] CMD_TE_DEVUELVE5 = 3'b101;
    localparam logic [2:0] CMD_TE           = 3'b110;
    localparam logic [2:0] CMD_CAFE         = 3'b111;

    // Default phase lengths in cycles.
    localparam int T_DOSIS_DEF  = 8;
    localparam int T_AGUA_DEF   = 16;
    localparam int T_MONEDA_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MONEDA     = 3'd1,
        ST_DOSIS_CAFE = 3'd2,
        ST_DOSIS_TE   = 3'd3,
        ST_AGUA       = 3'd4
    } estado_t;

    // The four job codes are exactly the codes with the MSB set.
    function automatic logic cmd_valido(input logic [2:0] c);
        return c[2];
    endfunction

    function automatic estado_t primera_fase(input logic [2:0] c);
        case (c)
            CMD_DEVUELVE,
            CMD_TE_DEVUELVE5: return ST_MONEDA;
            CMD_CAFE:         return ST_DOSIS_CAFE;
            CMD_TE:           return ST_DOSIS_TE;
            default:          return ST_IDLE;
        endcase
    endfunction

    // Phase that follows 'e' within job 'job'; ST_IDLE means the job is done.
    function automatic estado_t fase_siguiente(input estado_t e, input logic [2:0] job);
        case (e)
            ST_MONEDA:     return (job == CMD_TE_DEVUELVE5) ? ST_DOSIS_TE : ST_IDLE;
            ST_DOSIS_CAFE: return ST_AGUA;
            ST_DOSIS_TE:   return ST_AGUA;
            default:       return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dispensador_bebidas_temporizador.sv
// ---------------------------------------------------------------------------
// temporizador_fase
// Loadable 8-bit down-counter that times one dispenser phase.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low (count -> 0)
//   i_carga  : load i_valor (has priority over i_en)
//   i_valor  : phase length to load
//   i_en     : decrement enable
//   o_fin    : terminal flag, count == 1 (last cycle of the phase)
// The counter saturates at 1 so a stalled enable never wraps it.
// ---------------------------------------------------------------------------
module temporizador_fase (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_carga,
    input  logic [7:0] i_valor,
    input  logic       i_en,
    output logic       o_fin
);

    logic [7:0] r_cuenta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cuenta <= 8'd0;
        end else if (i_carga) begin
            r_cuenta <= i_valor;
        end else if (i_en && (r_cuenta > 8'd1)) begin
            r_cuenta <= r_cuenta - 8'd1;
        end
    end

    assign o_fin = (r_cuenta == 8'd1);

endmodule

// File: rtl/dispensador_bebidas.sv
// ---------------------------------------------------------------------------
// dispensador_bebidas
// Drink dispenser sequencer. Each command starts a job made of timed phases
// (coin return, powder dosing, hot water). One extra command can be held in
// a pending slot while a job runs; a further one is dropped and reported.
//   clk             : clock, rising edge
//   rst             : asynchronous reset, active low
//   cmd[2:0]        : one-cycle command code, 000 = idle
//   dosis_cafe      : coffee doser on
//   dosis_te        : tea doser on
//   valvula_agua    : hot-water valve open
//   devuelve_moneda : coin-return solenoid on
//   ocupado         : a job is running or one is pending
//   cmd_perdido     : one-cycle pulse, a command was dropped
//   o_estado        : current FSM state (debug)
//
// Handshake: cmd is a fire-and-forget strobe with no ready. A code with
// bit 2 set is consumed at the rising edge where it is sampled; if it cannot
// be started or stored, cmd_perdido is high in the following cycle.
// ---------------------------------------------------------------------------
module dispensador_bebidas
    import dispensador_bebidas_pkg::*;
#(
    parameter int T_DOSIS  = T_DOSIS_DEF,
    parameter int T_AGUA   = T_AGUA_DEF,
    parameter int T_MONEDA = T_MONEDA_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    output logic       dosis_cafe,
    output logic       dosis_te,
    output logic       valvula_agua,
    output logic       devuelve_moneda,
    output logic       ocupado,
    output logic       cmd_perdido,
    output estado_t    o_estado
);

    estado_t    r_estado;
    logic [2:0] r_job;
    logic       r_pend_v;
    logic [2:0] r_pend_cmd;
    logic       r_perdido;

    estado_t    w_estado_sig;
    estado_t    w_fase_sig;
    logic [2:0] w_job_sig;
    logic       w_pend_v_sig;
    logic [2:0] w_pend_cmd_sig;
    logic       w_perdido_sig;
    logic       w_carga;
    logic [7:0] w_valor_carga;
    logic       w_en;
    logic       w_fin;
    logic       w_cmd_valido;

    function automatic logic [7:0] duracion(input estado_t e);
        case (e)
            ST_MONEDA:     duracion = 8'(T_MONEDA);
            ST_DOSIS_CAFE: duracion = 8'(T_DOSIS);
            ST_DOSIS_TE:   duracion = 8'(T_DOSIS);
            ST_AGUA:       duracion = 8'(T_AGUA);
            default:       duracion = 8'd0;
        endcase
    endfunction

    assign w_cmd_valido  = cmd_valido(cmd);
    assign w_en          = (r_estado != ST_IDLE);
    assign w_valor_carga = duracion(w_estado_sig);

    temporizador_fase u_temporizador (
        .clk     (clk),
        .rst     (rst),
        .i_carga (w_carga),
        .i_valor (w_valor_carga),
        .i_en    (w_en),
        .o_fin   (w_fin)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado   <= ST_IDLE;
            r_job      <= CMD_NINGUNO;
            r_pend_v   <= 1'b0;
            r_pend_cmd <= CMD_NINGUNO;
            r_perdido  <= 1'b0;
        end else begin
            r_estado   <= w_estado_sig;
            r_job      <= w_job_sig;
            r_pend_v   <= w_pend_v_sig;
            r_pend_cmd <= w_pend_cmd_sig;
            r_perdido  <= w_perdido_sig;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_sig   = r_estado;
        w_job_sig      = r_job;
        w_pend_v_sig   = r_pend_v;
        w_pend_cmd_sig = r_pend_cmd;
        w_perdido_sig  = 1'b0;
        w_carga        = 1'b0;
        w_fase_sig     = fase_siguiente(r_estado, r_job);

        if (r_estado == ST_IDLE) begin
            // Pending is always empty in IDLE, so a command starts directly.
            if (w_cmd_valido) begin
                w_estado_sig = primera_fase(cmd);
                w_job_sig    = cmd;
                w_carga      = 1'b1;
            end
        end else if (w_fin && (w_fase_sig == ST_IDLE)) begin
            // Last cycle of the job: pending first, then a fresh command.
            if (r_pend_v) begin
                w_estado_sig = primera_fase(r_pend_cmd);
                w_job_sig    = r_pend_cmd;
                w_carga      = 1'b1;
                // Slot is freed this cycle, so a simultaneous command refills it.
                w_pend_v_sig = w_cmd_valido;
                if (w_cmd_valido) begin
                    w_pend_cmd_sig = cmd;
                end
            end else if (w_cmd_valido) begin
                w_estado_sig = primera_fase(cmd);
                w_job_sig    = cmd;
                w_carga      = 1'b1;
            end else begin
                w_estado_sig = ST_IDLE;
            end
        end else begin
            if (w_fin) begin
                // Next phase of the same job, no gap cycle.
                w_estado_sig = w_fase_sig;
                w_carga      = 1'b1;
            end
            if (w_cmd_valido) begin
                if (!r_pend_v) begin
                    w_pend_v_sig   = 1'b1;
                    w_pend_cmd_sig = cmd;
                end else begin
                    w_perdido_sig = 1'b1;
                end
            end
        end
    end

    // Moore output decode: one output per phase, so at most one is ever high.
    assign devuelve_moneda = (r_estado == ST_MONEDA);
    assign dosis_cafe      = (r_estado == ST_DOSIS_CAFE);
    assign dosis_te        = (r_estado == ST_DOSIS_TE);
    assign valvula_agua    = (r_estado == ST_AGUA);
    assign ocupado         = (r_estado != ST_IDLE) || r_pend_v;
    assign cmd_perdido     = r_perdido;
    assign o_estado        = r_estado;

endmodule

// File: tb/tb_dispensador_bebidas.sv
// Directed bench for dispensador_bebidas with default parameters.
// Each expected vector is {ocupado, devuelve_moneda, dosis_cafe, dosis_te,
// valvula_agua, cmd_perdido} for the cycle following the edge that samples
// the cmd driven in the same step.
module tb_dispensador_bebidas;

  localparam logic [5:0] OC   = 6'b100000;
  localparam logic [5:0] MON  = 6'b010000;
  localparam logic [5:0] CAFE = 6'b001000;
  localparam logic [5:0] TE   = 6'b000100;
  localparam logic [5:0] AGUA = 6'b000010;
  localparam logic [5:0] PERD = 6'b000001;

  logic       clk;
  logic       rst;
  logic [2:0] cmd;
  logic       dosis_cafe;
  logic       dosis_te;
  logic       valvula_agua;
  logic       devuelve_moneda;
  logic       ocupado;
  logic       cmd_perdido;
  logic [2:0] estado_dbg;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_vec = 0;

  dispensador_bebidas dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (cmd),
    .dosis_cafe      (dosis_cafe),
    .dosis_te        (dosis_te),
    .valvula_agua    (valvula_agua),
    .devuelve_moneda (devuelve_moneda),
    .ocupado         (ocupado),
    .cmd_perdido     (cmd_perdido),
    .o_estado        (estado_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] salidas();
    return {ocupado, devuelve_moneda, dosis_cafe, dosis_te, valvula_agua, cmd_perdido};
  endfunction

  task automatic comprobar(input string nombre, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s obtenido=%b esperado=%b", nombre, act, exp);
    end
  endtask

  // driver tasks
  task automatic paso(input logic [2:0] c, input logic [5:0] e);
    @(negedge clk);
    cmd = c;
    exp_q.push_back(e);
  endtask

  task automatic pasos(input logic [5:0] e, input int n);
    for (int i = 0; i < n; i++) paso(3'b000, e);
  endtask

  // monitor / scoreboard
  initial begin
    logic [5:0] exp_v;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (salidas() !== exp_v) begin
          n_errors++;
          $display("FAIL salida[%0d] obtenido=%b esperado=%b", n_vec, salidas(), exp_v);
        end
        n_vec++;
      end
    end
  end

  initial begin
    cmd = 3'b000;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 comprobar("reset_inicial", {2'b00, salidas()}, 8'd0);
    comprobar("estado_reset", {5'd0, estado_dbg}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pasos(6'd0, 2);

    // coffee: 8 dosing + 16 water, then idle
    paso(3'b111, OC | CAFE);
    pasos(OC | CAFE, 7);
    pasos(OC | AGUA, 16);
    pasos(6'd0, 3);

    // tea with coin return: 4 + 8 + 16 contiguous
    paso(3'b101, OC | MON);
    pasos(OC | MON, 3);
    pasos(OC | TE, 8);
    pasos(OC | AGUA, 16);
    pasos(6'd0, 2);

    // tea, then coin return queued five cycles later
    paso(3'b110, OC | TE);
    pasos(OC | TE, 4);
    paso(3'b100, OC | TE);
    pasos(OC | TE, 2);
    pasos(OC | AGUA, 16);
    pasos(OC | MON, 4);
    pasos(6'd0, 2);

    // coffee, 100 pending, 110 dropped
    paso(3'b111, OC | CAFE);
    paso(3'b100, OC | CAFE);
    paso(3'b110, OC | CAFE | PERD);
    pasos(OC | CAFE, 5);
    pasos(OC | AGUA, 16);
    pasos(OC | MON, 4);
    pasos(6'd0, 2);

    // pending consumed while a new cmd arrives on the final cycle
    paso(3'b111, OC | CAFE);
    paso(3'b100, OC | CAFE);
    pasos(OC | CAFE, 6);
    pasos(OC | AGUA, 16);
    paso(3'b110, OC | MON);
    pasos(OC | MON, 3);
    pasos(OC | TE, 8);
    pasos(OC | AGUA, 16);
    pasos(6'd0, 2);

    // no pending: cmd on the final cycle starts with no idle gap
    paso(3'b100, OC | MON);
    pasos(OC | MON, 3);
    paso(3'b111, OC | CAFE);
    pasos(OC | CAFE, 7);
    pasos(OC | AGUA, 16);
    pasos(6'd0, 2);

    // ignored codes
    paso(3'b001, 6'd0);
    paso(3'b010, 6'd0);
    paso(3'b011, 6'd0);
    pasos(6'd0, 2);

    // asynchronous reset during the water phase
    paso(3'b111, OC | CAFE);
    pasos(OC | CAFE, 7);
    pasos(OC | AGUA, 5);
    @(posedge clk);
    #4 rst = 1'b0;
    #1 comprobar("reset_asincrono", {2'b00, salidas()}, 8'd0);
    comprobar("estado_tras_reset", {5'd0, estado_dbg}, 8'd0);
    paso(3'b111, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    cmd = 3'b100;
    exp_q.push_back(OC | MON);
    pasos(OC | MON, 3);
    pasos(6'd0, 2);

    // drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drenaje pendientes=%0d esperado=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
